fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/mips_pkg.sv | 14 +
 rtl/fetch_ctrl.sv | 130 +++++++++++++
 tb/tb_fetch_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS front-end types and vector constants
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] EXC_VECTOR   = 32'hBFC00380;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer between PC register, imem and decode
module fetch_ctrl #(
    parameter int                 WIDTH      = 32,
    parameter logic [WIDTH-1:0]   EXC_VECTOR = WIDTH'(mips_pkg::EXC_VECTOR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_q,
    output logic             pc_en,
    output logic [WIDTH-1:0] pc_d,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             instr_ready,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             exc
);
    import mips_pkg::*;

    localparam logic [WIDTH-1:0] WORD_MASK = ~WIDTH'(3);

    fetch_state_t     state, state_nxt;
    logic [WIDTH-1:0] pend_q, pend_nxt;
    logic             pend_exc_q, pend_exc_nxt;
    logic             capture;
    logic             redirect;
    logic [WIDTH-1:0] redir_tgt;

    // Exception wins over a branch redirect raised in the same cycle.
    assign redirect  = exc | redir_valid;
    assign redir_tgt = exc ? (EXC_VECTOR & WORD_MASK) : (redir_target & WORD_MASK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pend_q     <= '0;
            pend_exc_q <= 1'b0;
            instr      <= '0;
            instr_pc   <= '0;
        end else begin
            state      <= state_nxt;
            pend_q     <= pend_nxt;
            pend_exc_q <= pend_exc_nxt;
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= pc_q;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        pend_nxt     = pend_q;
        pend_exc_nxt = pend_exc_q;
        capture      = 1'b0;
        pc_en        = 1'b0;
        pc_d         = '0;
        imem_req     = 1'b0;
        imem_addr    = '0;
        instr_valid  = 1'b0;

        case (state)
            IDLE: begin
                if (redirect) begin
                    pc_en = 1'b1;
                    pc_d  = redir_tgt;
                end
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc_q;
                if (imem_ack) begin
                    pc_en = 1'b1;
                    if (redirect) begin
                        pc_d = redir_tgt;
                    end else begin
                        pc_d      = pc_q + WIDTH'(4);
                        capture   = 1'b1;
                        state_nxt = HOLD;
                    end
                end else if (redirect) begin
                    pend_nxt     = redir_tgt;
                    pend_exc_nxt = exc;
                    state_nxt    = DRAIN;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (redirect) begin
                    pc_en     = 1'b1;
                    pc_d      = redir_tgt;
                    state_nxt = FETCH;
                end else if (instr_ready) begin
                    state_nxt = FETCH;
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = pc_q;
                // A pending exception cannot be displaced by a plain branch redirect.
                if (redirect && !(pend_exc_q && !exc)) begin
                    pend_nxt     = redir_tgt;
                    pend_exc_nxt = exc;
                end
                if (imem_ack) begin
                    pc_en        = 1'b1;
                    pc_d         = pend_nxt;
                    pend_exc_nxt = 1'b0;
                    state_nxt    = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (!reset) begin
            pc_en       = 1'b0;
            pc_d        = '0;
            imem_req    = 1'b0;
            imem_addr   = '0;
            instr_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed plus randomized check of fetch_ctrl against a transaction-level model
module tb_fetch_ctrl;

    localparam logic [31:0] EXC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_q = 32'h0;
    logic        pc_en;
    logic [31:0] pc_d;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_target = 32'h0;
    logic        exc = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    // Model: what the fetch unit is doing, in transaction terms.
    bit          m_boot;
    bit          m_waiting;
    bit          m_discard;
    bit          m_holding;
    logic [31:0] m_pend;
    bit          m_pend_exc;
    logic [31:0] m_instr;
    logic [31:0] m_instr_pc;

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .pc_q(pc_q), .pc_en(pc_en), .pc_d(pc_d),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .redir_valid(redir_valid), .redir_target(redir_target), .exc(exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        m_boot = 1'b1; m_waiting = 1'b0; m_discard = 1'b0; m_holding = 1'b0;
        m_pend = 32'h0; m_pend_exc = 1'b0; m_instr = 32'h0; m_instr_pc = 32'h0;
    endtask

    task automatic step(input bit a, input bit r, input bit rv, input logic [31:0] rt,
                        input bit e, input logic [31:0] rd);
        bit          redir;
        logic [31:0] tgt, eff;
        bit          x_en, x_req, x_valid;
        logic [31:0] x_d, x_addr;
        imem_ack = a; instr_ready = r; redir_valid = rv; redir_target = rt; exc = e; imem_rdata = rd;
        @(negedge clk);
        redir = e | rv;
        tgt   = e ? EXC : (rt & 32'hFFFF_FFFC);
        x_en = 1'b0; x_d = 32'h0; x_req = 1'b0; x_addr = 32'h0; x_valid = 1'b0;
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_instr_pc);
        if (m_boot) begin
            if (redir) begin x_en = 1'b1; x_d = tgt; end
            m_boot = 1'b0; m_waiting = 1'b1;
        end else if (m_holding) begin
            x_valid = 1'b1;
            if (redir) begin x_en = 1'b1; x_d = tgt; end
            if (redir || r) begin m_holding = 1'b0; m_waiting = 1'b1; end
        end else if (m_waiting) begin
            x_req = 1'b1; x_addr = pc_q;
            if (m_discard) begin
                eff = m_pend;
                if (redir && !(m_pend_exc && !e)) begin eff = tgt; m_pend_exc = e; end
                m_pend = eff;
                if (a) begin x_en = 1'b1; x_d = eff; m_discard = 1'b0; m_pend_exc = 1'b0; end
            end else if (a) begin
                x_en = 1'b1;
                if (redir) x_d = tgt;
                else begin
                    x_d = pc_q + 32'd4;
                    m_instr = rd; m_instr_pc = pc_q;
                    m_waiting = 1'b0; m_holding = 1'b1;
                end
            end else if (redir) begin
                m_discard = 1'b1; m_pend = tgt; m_pend_exc = e;
            end
        end
        chk("pc_en", {31'h0, pc_en}, {31'h0, x_en});
        chk("pc_d", pc_d, x_d);
        chk("imem_req", {31'h0, imem_req}, {31'h0, x_req});
        chk("imem_addr", imem_addr, x_addr);
        chk("instr_valid", {31'h0, instr_valid}, {31'h0, x_valid});
        @(posedge clk);
        #1;
        if (x_en) pc_q = x_d;
    endtask

    // Asserts reset between edges with a late ack outstanding, then releases it.
    task automatic do_reset(input logic [31:0] pc_after);
        imem_ack = 1'b1; redir_valid = 1'b1; exc = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
        chk("rst_pc_en", {31'h0, pc_en}, 32'h0);
        chk("rst_pc_d", pc_d, 32'h0);
        chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_late_ack_pc_en", {31'h0, pc_en}, 32'h0);
        imem_ack = 1'b0; redir_valid = 1'b0;
        pc_q = pc_after;
        model_clear();
        reset = 1'b1;
    endtask

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        do_reset(32'hBFC0_0000);

        // Boot fetch with ack two cycles after the request.
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 32'h2408_0001);
        chk("boot_pc", pc_q, 32'hBFC0_0004);
        // Decode stalls for five cycles.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 32'hDEAD_0000 + i);
        chk("boot_instr_pc", instr_pc, 32'hBFC0_0000);
        step(0, 1, 0, 0, 0, 0);

        // Branch during an un-acked fetch goes through DRAIN.
        step(0, 0, 1, 32'h0040_0013, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 32'hBAD0_BAD0);
        chk("drain_pc", pc_q, 32'h0040_0010);
        step(1, 0, 0, 0, 0, 32'h1111_1111);

        // Exception and branch together while holding.
        step(0, 1, 1, 32'h1234_5678, 1, 0);
        chk("exc_pc", pc_q, EXC);
        step(0, 0, 0, 0, 0, 0);

        // Exception pending in DRAIN survives a later branch.
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 32'h0000_1000, 0, 0);
        step(1, 0, 0, 0, 0, 32'h5555_5555);
        chk("drain_exc_keep", pc_q, EXC);

        // PC increment wraps at the top of the address space.
        step(1, 0, 1, 32'hFFFF_FFFF, 0, 0);
        step(1, 0, 0, 0, 0, 32'h7777_7777);
        chk("wrap_pc", pc_q, 32'h0000_0000);
        step(0, 1, 0, 0, 0, 0);

        // Reset in the middle of a fetch handshake.
        step(0, 0, 0, 0, 0, 0);
        do_reset(32'hBFC0_0000);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset($urandom & 32'hFFFF_FFFC);
            else step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
                      $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 19) == 0, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
